// File: rtl/key_event_pkg.sv
// Shared types and constants for the key_event debouncer/event queue.
package key_pkg;

   typedef logic [3:0] key_t;

   typedef enum logic [1:0] {
      UNARMED  = 2'd0,
      STABLE   = 2'd1,
      SETTLING = 2'd2
   } state_t;

   localparam int unsigned STABLE_CYCLES_DEF = 200000;
   localparam int          CNT_W             = 20;

endpackage

// File: rtl/key_event_fifo.sv
// Event queue for key_event: a ring of DEPTH entries, or a single holding
// register when DEPTH is 1. A pop frees room for a push in the same cycle.
module key_event_fifo
   import key_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  key_t       push_code,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output logic [4:0] count,
   output key_t       head
);

   logic [4:0] count_r;
   logic       do_push;
   logic       do_pop;

   assign empty   = (count_r == 5'd0);
   assign full    = (count_r == 5'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = count_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r <= 5'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   count_r <= count_r + 5'd1;
            2'b01:   count_r <= count_r - 5'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   generate
      if (DEPTH == 1) begin : g_single
         key_t hold_r;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               hold_r <= 4'h0;
            end else if (do_push) begin
               hold_r <= push_code;
            end else begin
               hold_r <= hold_r;
            end
         end

         assign head = empty ? 4'h0 : hold_r;
      end else begin : g_ring
         localparam int PW = $clog2(DEPTH);
         key_t          mem_r [DEPTH];
         logic [PW-1:0] rd_r;
         logic [PW-1:0] wr_r;

         // Power-of-two depth lets the pointers wrap by plain overflow.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rd_r <= '0;
               wr_r <= '0;
               for (int i = 0; i < DEPTH; i++) begin
                  mem_r[i] <= 4'h0;
               end
            end else begin
               if (do_push) begin
                  mem_r[wr_r] <= push_code;
                  wr_r        <= wr_r + PW'(1);
               end
               if (do_pop) begin
                  rd_r <= rd_r + PW'(1);
               end
            end
         end

         assign head = empty ? 4'h0 : mem_r[rd_r];
      end
   endgenerate

endmodule

// File: rtl/key_event.sv
// Keypad debouncer: emits one queued event per accepted key-code change.
// Define KEY_EVENT_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise depth 1.
module key_event
   import key_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int          FIFO_DEPTH    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key_code,
   output logic       ev_valid,
   output logic [3:0] ev_code,
   input  logic       ev_ready,
   output logic       overflow,
   output logic [4:0] ev_count
);

`ifdef KEY_EVENT_FIFO_EN
   localparam int QDEPTH = FIFO_DEPTH;
`else
   // FIFO_DEPTH has no effect in the single-register build.
   localparam int QDEPTH = FIFO_DEPTH - FIFO_DEPTH + 1;
`endif

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

   state_t           state_r;
   state_t           state_n;
   key_t             cand_r;
   key_t             baseline_r;
   key_t             baseline_n;
   logic [CNT_W-1:0] cnt_r;
   logic             overflow_r;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;

   assign pop      = ev_valid && ev_ready;
   assign ev_valid = !empty;
   assign overflow = overflow_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand_r <= 4'h0;
         cnt_r  <= '0;
      end else if (key_code != cand_r) begin
         cand_r <= key_code;
         cnt_r  <= '0;
      end else if (cnt_r != LAST) begin
         cnt_r  <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r  <= cnt_r;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= UNARMED;
         baseline_r <= 4'h0;
         overflow_r <= 1'b0;
      end else begin
         state_r    <= state_n;
         baseline_r <= baseline_n;
         overflow_r <= overflow_r | (push && full && !pop);
      end
   end

   // The first qualified value after reset only sets the baseline.
   always_comb begin
      state_n    = state_r;
      baseline_n = baseline_r;
      push       = 1'b0;
      case (state_r)
         UNARMED: begin
            if (cnt_r == LAST) begin
               baseline_n = cand_r;
               state_n    = STABLE;
            end else begin
               state_n    = UNARMED;
            end
         end
         STABLE: begin
            if (key_code != baseline_r) begin
               state_n = SETTLING;
            end else begin
               state_n = STABLE;
            end
         end
         SETTLING: begin
            if (cnt_r == LAST) begin
               state_n = STABLE;
               if (cand_r != baseline_r) begin
                  push       = 1'b1;
                  baseline_n = cand_r;
               end else begin
                  push       = 1'b0;
               end
            end else begin
               state_n = SETTLING;
            end
         end
         default: begin
            state_n = UNARMED;
         end
      endcase
   end

   key_event_fifo #(
      .DEPTH(QDEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_code (cand_r),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .count     (ev_count),
      .head      (ev_code)
   );

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter STABLE_CYCLES, default 200000, SHALL set the clock cycles key_code must hold unchanged before being accepted (2 ms at 100 MHz); legal range 2..2^20-1.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set event queue depth when KEY_EVENT_FIFO_EN is defined; power of two, 2..16.
REQ-003 clk  input  1  100 MHz onboard clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 key_code  input  4  held key value from the keypad scanner, synchronous to clk.
REQ-006 ev_valid  output  1  an event is available on ev_code.
REQ-007 ev_code  output  4  key value of the head event.
REQ-008 ev_ready  input  1  consumer accepts the head event this cycle.
REQ-009 overflow  output  1  sticky flag: an event was dropped.
REQ-010 ev_count  output  5  number of queued events.

Function
REQ-011 Candidate register cand and 20-bit counter cnt SHALL track key_code: if key_code != cand, cand<=key_code and cnt<=0; else cnt saturates at STABLE_CYCLES-1.
REQ-012 FSM states SHALL be UNARMED, STABLE and SETTLING.
REQ-013 UNARMED: when cnt reaches STABLE_CYCLES-1, baseline<=cand, go STABLE, no event.
REQ-014 STABLE: key_code != baseline moves to SETTLING next cycle.
REQ-015 SETTLING: when cnt reaches STABLE_CYCLES-1 and cand != baseline, baseline<=cand, push one event with code cand, go STABLE; if cand == baseline at that point, go STABLE with no event.
REQ-016 A value change and return within fewer than STABLE_CYCLES cycles SHALL produce no event.
REQ-017 A push SHALL be visible on ev_valid/ev_code the cycle after the commit cycle (1-cycle latency into an empty queue).
REQ-018 Handshake: pop occurs when ev_valid && ev_ready; ev_code SHALL be stable while ev_valid && !ev_ready.
REQ-019 Simultaneous push and pop SHALL be accepted in the same cycle at any occupancy, including full; ev_count unchanged.
REQ-020 Push when full without a pop SHALL drop the new event, keep queue contents, and set overflow to 1 until reset.
REQ-021 ev_ready while ev_valid is 0 SHALL have no effect; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-022 rst_n low at a clock edge SHALL set: state UNARMED, cand 4'h0, cnt 0, baseline 4'h0, queue empty, ev_valid 0, ev_code 4'h0, ev_count 0, overflow 0.
REQ-023 Reset mid-settling or with queued events SHALL discard all pending and queued events; key_code is re-qualified from UNARMED afterwards.

Configuration
REQ-024 Macro KEY_EVENT_FIFO_EN defined: queue is FIFO_DEPTH entries as above.
REQ-025 Macro KEY_EVENT_FIFO_EN undefined: queue is a single holding register (depth 1); REQ-019/020 apply with depth 1; FIFO_DEPTH ignored; ev_count is 0 or 1.

Structure
REQ-026 Package key_pkg SHALL hold the FSM state enum, the 4-bit key code typedef and the default STABLE_CYCLES constant.
REQ-027 One sub-module key_event_fifo SHALL implement the queue (both configurations), with push/pop/full/empty/count ports.

Verification (STABLE_CYCLES=8, FIFO_DEPTH=4, KEY_EVENT_FIFO_EN defined unless noted)
REQ-028 Reset release with key_code=4'h0 for 8 cycles, then 4'h5 for 8 cycles, ev_ready=1 -> no event for 4'h0; exactly one event 4'h5, ev_valid one cycle.
REQ-029 key_code toggles 4'h3 for 5 cycles then back to baseline -> no event, state returns STABLE.
REQ-030 ev_ready=0, five stable changes 4'h1,4'h2,4'h3,4'h4,4'h6 -> ev_count=4, overflow=1, drain order 1,2,3,4.
REQ-031 Queue full and ev_ready=1 on the commit cycle of 4'h9 -> ev_count stays 4, overflow stays 0, 4'h9 is the last entry.
REQ-032 rst_n low for 1 cycle while in SETTLING with 2 events queued -> all outputs at reset values next cycle, no event emitted for the settling value.
REQ-033 KEY_EVENT_FIFO_EN undefined, ev_ready=0, changes 4'hA then 4'hB -> ev_code=4'hA held, overflow=1, ev_count=1.
